// File: rtl/sum_display_scan.sv
// Captures the 5-bit adder result {co,sum}, converts it to two BCD digits and
// time-multiplexes them onto a 4-digit active-low seven-segment display.
module sum_display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sum,
    input  logic       co,
    input  logic       load,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {S_ONES, S_TENS, S_OFF2, S_OFF3} scan_t;

    scan_t         state, state_nxt;
    logic [4:0]    cap;
    logic          pend;
    logic [1:0]    tens, tens_c;
    logic [3:0]    ones, ones_c;
    logic [4:0]    rem;
    logic [CW-1:0] cnt;
    logic          wrap;
    logic [6:0]    seg_d;
    logic [3:0]    an_d;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b0000001;
            4'd1:    enc = 7'b1001111;
            4'd2:    enc = 7'b0010010;
            4'd3:    enc = 7'b0000110;
            4'd4:    enc = 7'b1001100;
            4'd5:    enc = 7'b0100100;
            4'd6:    enc = 7'b0100000;
            4'd7:    enc = 7'b0001111;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0001100;
            default: enc = SEG_BLANK;
        endcase
    endfunction

    // pend doubles as busy: set by a load edge, cleared once the commit edge passes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap  <= '0;
            pend <= 1'b0;
        end else begin
            if (load) cap <= {co, sum};
            pend <= load;
        end
    end

    assign busy = pend;

    always_comb begin
        tens_c = 2'd0;
        rem    = cap;
        if (cap >= 5'd30) begin
            tens_c = 2'd3;
            rem    = cap - 5'd30;
        end else if (cap >= 5'd20) begin
            tens_c = 2'd2;
            rem    = cap - 5'd20;
        end else if (cap >= 5'd10) begin
            tens_c = 2'd1;
            rem    = cap - 5'd10;
        end
        ones_c = rem[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= '0;
            ones <= '0;
        end else if (pend) begin
            tens <= tens_c;
            ones <= ones_c;
        end
    end

    assign wrap = (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (wrap) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_ONES;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        an_d      = 4'b1111;
        seg_d     = SEG_BLANK;
        case (state)
            S_ONES: begin
                an_d  = 4'b1110;
                seg_d = enc(ones);
                if (wrap) state_nxt = S_TENS;
            end
            S_TENS: begin
                if (!(BLANK_LZ && tens == 2'd0)) begin
                    an_d  = 4'b1101;
                    seg_d = enc({2'b00, tens});
                end
                if (wrap) state_nxt = S_OFF2;
            end
            S_OFF2: if (wrap) state_nxt = S_OFF3;
            S_OFF3: if (wrap) state_nxt = S_ONES;
            default: state_nxt = S_ONES;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= 1'b1;
        end
    end

endmodule
